// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//   Buffers an N x N activation tile (one row per handshake) and streams it
//   into the systolic array west edge with diagonal skew: lane i lags lane 0
//   by i steps. A one-cycle done pulse follows the last accepted feed step.
//
// Build option:
//   SKEW_FEEDER_TRANSPOSE_EN - lane i reads tile[i][step-i] instead of
//                              tile[step-i][i] (transposed feed, same valids).
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   in_valid/ready   row handshake; in_row element j at [j*DATA_W +: DATA_W]
//   out_data         lane i at [i*DATA_W +: DATA_W]
//   out_valid        per-lane valid
//   out_ready        array enable, advances the feed step
//   busy             high in LOAD, FEED and DONE
//   done             one-cycle pulse after the final feed step
module systolic_skew_feeder #(
  parameter int N      = 4,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_row,
  output logic [N*DATA_W-1:0] out_data,
  output logic [N-1:0]        out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
);
  localparam int ROW_W  = $clog2(N);
  localparam int STEP_W = $clog2(2*N-1);

  typedef enum logic [1:0] {IDLE, LOAD, FEED, DONE} state_t;

  state_t                            r_state, w_state_nx;
  logic [ROW_W-1:0]                  r_row_cnt, w_row_nx;
  logic [STEP_W-1:0]                 r_step, w_step_nx;
  logic [N-1:0][N-1:0][DATA_W-1:0]   r_tile;
  logic                              w_accept;
  logic                              w_feed;

  assign in_ready = (r_state == IDLE) || (r_state == LOAD);
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign w_feed   = (r_state == FEED);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_row_cnt <= '0;
      r_step    <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_row_cnt <= w_row_nx;
      r_step    <= w_step_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_row_nx   = r_row_cnt;
    w_step_nx  = r_step;
    case (r_state)
      IDLE: if (w_accept) begin
        // N >= 2, so a single row never completes the tile.
        w_row_nx   = ROW_W'(1);
        w_state_nx = LOAD;
      end
      LOAD: if (w_accept) begin
        if (r_row_cnt == ROW_W'(N-1)) begin
          w_row_nx   = '0;
          w_step_nx  = '0;
          w_state_nx = FEED;
        end else begin
          w_row_nx = r_row_cnt + ROW_W'(1);
        end
      end
      FEED: if (out_ready) begin
        if (r_step == STEP_W'(2*N-2)) begin
          w_step_nx  = '0;
          w_state_nx = DONE;
        end else begin
          w_step_nx = r_step + STEP_W'(1);
        end
      end
      DONE: w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Tile storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int c = 0; c < N; c++)
        r_tile[r_row_cnt][c] <= in_row[c*DATA_W +: DATA_W];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [STEP_W:0]   w_diff;
    logic              w_in;
    logic [ROW_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_sel;

    // Lane is live while 0 <= step-i < N; the extra bit keeps the
    // subtraction from aliasing back into range when step < i.
    assign w_diff = {1'b0, r_step} - (STEP_W+1)'(gi);
    assign w_in   = (r_step >= STEP_W'(gi)) && (w_diff < (STEP_W+1)'(N));
    assign w_idx  = w_diff[ROW_W-1:0];
`ifdef SKEW_FEEDER_TRANSPOSE_EN
    assign w_sel  = r_tile[gi][w_idx];
`else
    assign w_sel  = r_tile[w_idx][gi];
`endif
    assign out_valid[gi]                 = w_feed && w_in;
    assign out_data[gi*DATA_W +: DATA_W] = (w_feed && w_in) ? w_sel : '0;
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;
  localparam int N = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [N*DW-1:0] in_row;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]  out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_d1 [7];
  logic [31:0] exp_d2 [7];
  logic [3:0]  exp_v  [7];

  systolic_skew_feeder #(.N(N), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one tile: row r element j = base + 4r + j + 1. With gap set, an
  // idle cycle carrying junk data precedes every row.
  task automatic load_tile(input int base, input bit gap);
    for (int r = 0; r < N; r++) begin
      if (gap) begin
        in_valid = 1'b0;
        in_row   = 32'hEEEEEEEE;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 4'b0) begin
          errors++;
          $display("FAIL load_gap: in_ready=%b out_valid=%b required 1/0000", in_ready, out_valid);
        end
      end
      in_valid = 1'b1;
      for (int j = 0; j < N; j++) in_row[j*DW +: DW] = 8'(base + 4*r + j + 1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_row = '0; out_ready = 1'b1;
    tick(); tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 4'b0 || out_data !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b data=%h busy=%b done=%b required 1/0000/0/0/0",
               in_ready, out_valid, out_data, busy, done);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    load_tile(0, 1'b0);
    for (int s = 0; s < 7; s++) begin
      checks++;
      if (out_data !== exp_d1[s] || out_valid !== exp_v[s] || done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL basic step%0d: data=%h vld=%b done=%b busy=%b required %h/%b/0/1",
                 s, out_data, out_valid, done, busy, exp_d1[s], exp_v[s]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || out_valid !== 4'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: done=%b vld=%b rdy=%b busy=%b required 1/0000/0/1", done, out_valid, in_ready, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle: done=%b busy=%b rdy=%b required 0/0/1", done, busy, in_ready);
    end
  endtask

  task automatic test_stall();
    load_tile(0, 1'b0);
    for (int s = 0; s < 7; s++) begin
      checks++;
      if (out_data !== exp_d1[s] || out_valid !== exp_v[s]) begin
        errors++;
        $display("FAIL stall step%0d: data=%h vld=%b required %h/%b", s, out_data, out_valid, exp_d1[s], exp_v[s]);
      end
      if (s == 2) begin
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          checks++;
          if (out_data !== 32'h00030609 || out_valid !== 4'b0111 || done !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d: data=%h vld=%b done=%b required 00030609/0111/0", k, out_data, out_valid, done);
          end
        end
        out_ready = 1'b1;
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: done=%b required 1", done);
    end
    tick();
  endtask

  task automatic test_load_backpressure();
    load_tile(0, 1'b1);
    // Keep offering a junk row through FEED; it must not be taken.
    in_valid = 1'b1;
    in_row   = 32'hFFFFFFFF;
    for (int s = 0; s < 7; s++) begin
      checks++;
      if (out_data !== exp_d1[s] || out_valid !== exp_v[s] || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp step%0d: data=%h vld=%b rdy=%b required %h/%b/0",
                 s, out_data, out_valid, in_ready, exp_d1[s], exp_v[s]);
      end
      if (s == 6) in_valid = 1'b0;
      tick();
    end
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: done=%b rdy=%b required 1/0", done, in_ready);
    end
    tick();
  endtask

  task automatic test_reset_mid_feed();
    int done_seen;
    load_tile(0, 1'b0);
    tick(); tick(); tick();
    checks++;
    if (out_data !== exp_d1[3] || out_valid !== 4'b1111) begin
      errors++;
      $display("FAIL rst_mid_step3: data=%h vld=%b required %h/1111", out_data, out_valid, exp_d1[3]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 4'b0 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: vld=%b rdy=%b busy=%b done=%b data=%h required 0000/1/0/0/0",
               out_valid, in_ready, busy, done, out_data);
    end
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL rst_mid_nodone: done pulses=%0d required 0", done_seen);
    end
    load_tile(16, 1'b0);
    for (int s = 0; s < 7; s++) begin
      checks++;
      if (out_data !== exp_d2[s] || out_valid !== exp_v[s]) begin
        errors++;
        $display("FAIL rst_mid_fresh step%0d: data=%h vld=%b required %h/%b", s, out_data, out_valid, exp_d2[s], exp_v[s]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_fresh_done: done=%b required 1", done);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    load_tile(0, 1'b0);
    // Second tile's first row waits on in_valid for the whole first feed.
    in_valid = 1'b1;
    for (int j = 0; j < N; j++) in_row[j*DW +: DW] = 8'(16 + j + 1);
    for (int s = 0; s < 7; s++) begin
      checks++;
      if (out_data !== exp_d1[s] || out_valid !== exp_v[s] || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_t1 step%0d: data=%h vld=%b rdy=%b required %h/%b/0",
                 s, out_data, out_valid, in_ready, exp_d1[s], exp_v[s]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: done=%b rdy=%b required 1/0", done, in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: rdy=%b busy=%b required 1/0", in_ready, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_row0_taken: busy=%b rdy=%b required 1/1", busy, in_ready);
    end
    for (int r = 1; r < N; r++) begin
      for (int j = 0; j < N; j++) in_row[j*DW +: DW] = 8'(16 + 4*r + j + 1);
      tick();
    end
    in_valid = 1'b0;
    for (int s = 0; s < 7; s++) begin
      checks++;
      if (out_data !== exp_d2[s] || out_valid !== exp_v[s]) begin
        errors++;
        $display("FAIL b2b_t2 step%0d: data=%h vld=%b required %h/%b", s, out_data, out_valid, exp_d2[s], exp_v[s]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_t2_done: done=%b required 1", done);
    end
    tick();
  endtask

  initial begin
    exp_v = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
`ifdef SKEW_FEEDER_TRANSPOSE_EN
    exp_d1 = '{32'h00000001, 32'h00000502, 32'h00090603, 32'h0D0A0704,
               32'h0E0B0800, 32'h0F0C0000, 32'h10000000};
    exp_d2 = '{32'h00000011, 32'h00001512, 32'h00191613, 32'h1D1A1714,
               32'h1E1B1800, 32'h1F1C0000, 32'h20000000};
`else
    exp_d1 = '{32'h00000001, 32'h00000205, 32'h00030609, 32'h04070A0D,
               32'h080B0E00, 32'h0C0F0000, 32'h10000000};
    exp_d2 = '{32'h00000011, 32'h00001215, 32'h00131619, 32'h14171A1D,
               32'h181B1E00, 32'h1C1F0000, 32'h20000000};
`endif
    test_reset();
    test_basic();
    test_stall();
    test_load_backpressure();
    test_reset_mid_feed();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Sits directly upstream of the systolic array inside tpu.
- Accepts an N x N activation tile from the unified buffer one row per handshake.
- Streams the tile into the array's west edge with diagonal skew: lane i is delayed i steps, so operands meet the correct PE wavefront.
- Signals completion so the controller can issue the next tile.

Parameters:
- N, 4, tile dimension and number of output lanes (N >= 2).
- DATA_W, 8, bits per activation element.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_row holds a valid tile row.
- in_ready  output  1  block can accept a row.
- in_row  input  N*DATA_W  one tile row; element j is at bits [j*DATA_W +: DATA_W].
- out_data  output  N*DATA_W  lane i at bits [i*DATA_W +: DATA_W], fed to array row i.
- out_valid  output  N  per-lane valid.
- out_ready  input  1  array enable; the step advances only when this is high.
- busy  output  1  high in LOAD, FEED and DONE.
- done  output  1  one-cycle pulse after the final feed step is accepted.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset values:
  - state=IDLE, row_cnt=0, step=0.
  - in_ready=1, out_valid=0, out_data=0, busy=0, done=0.
  - Tile storage is not cleared.
- Reset mid-operation: abandons the tile, returns to IDLE next cycle, and produces no done pulse.
- Storage and output paths:
  - Tile storage is N x N registers, tile[r][c].
  - Outputs are decoded from registered state, tile and step only. There is no combinational path from inputs to outputs.
- Row handshake: a row is accepted on a rising edge when in_valid && in_ready. Accepted row r is written to tile[r][*], where r = row_cnt.
- State machine:
  - IDLE: in_ready=1. An accepted row writes tile[0] and sets row_cnt=1. Go to LOAD, or go straight to FEED if N rows are already stored (not possible for N >= 2).
  - LOAD: in_ready=1. Each accepted row writes tile[row_cnt] and increments row_cnt. When row N-1 is accepted, go to FEED with step=0 and row_cnt=0.
  - FEED: in_ready=0; in_valid is ignored.
    - For each lane i: if 0 <= step-i < N, then out_valid[i]=1 and lane data = tile[step-i][i]. Otherwise out_valid[i]=0 and lane data = 0.
    - When out_ready=1, step increments.
    - When out_ready=0, step and all outputs hold unchanged (stall of any length).
    - When step == 2N-2 and out_ready=1, go to DONE.
  - DONE: done=1 for exactly one cycle, out_valid=0, in_ready=0. Unconditionally go to IDLE.
- Timing:
  - Total feed length is 2N-1 accepted steps.
  - Minimum tile turnaround is N load cycles + (2N-1) feed cycles + 1 DONE cycle.
- Boundary conditions:
  - in_valid held high across the LOAD→FEED edge: the extra row is not accepted (in_ready drops in the FEED cycle).
  - in_valid low during LOAD: row_cnt holds; there is no timeout.
  - step width is ceil(log2(2N-1)); the counter never wraps past 2N-2.

Optional Feature:
- Macro: SKEW_FEEDER_TRANSPOSE_EN.
- When defined, the FEED data select becomes lane i = tile[i][step-i]. The valid pattern is unchanged, so the tile is fed transposed (weight-stationary ordering).
- When undefined, the select is lane i = tile[step-i][i], as specified above.
- No port or parameter changes in either case.

Test Plan:
- Basic tile: N=4, DATA_W=8, rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} with out_ready=1.
  - Step 0: lane0=1 only.
  - Step 1: lane0=5, lane1=2.
  - Step 3: lanes=13,10,7,4, all valid.
  - Step 6: lane3=16 only.
  - done pulses exactly 1 cycle after step 6; busy falls in the next cycle.
- Stall: same tile, out_ready=0 for 3 cycles at step 2.
  - out_data={9,6,3,0} and out_valid=4'b0111 held for 3 cycles.
  - Sequence resumes at step 3 with no step skipped or repeated.
- Backpressure on load: in_valid toggled 1,0,1,0,...
  - Only accepted rows are stored; FEED starts the cycle after the 4th acceptance.
  - in_ready=0 throughout FEED even with in_valid=1.
- Reset mid-feed: assert reset at step 3.
  - Next cycle: out_valid=0, in_ready=1, done never pulses.
  - A fresh tile loads and feeds correctly.
- Back-to-back tiles: second tile's rows presented while the first is feeding; in_valid is held.
  - Second tile's first row is accepted the cycle after DONE.
  - Second tile's output matches expected skew.
- Transpose build: SKEW_FEEDER_TRANSPOSE_EN defined, basic tile.
  - Step 1: lane0=2, lane1=5.
  - Step 3: lanes=4,7,10,13.
